muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer beside the 32-bit execute ALU. It owns the HI/LO register pair and runs mult, multu, div and divu as a 32-iteration shift-add / restoring-divide engine. A combinational stall holds the single-cycle PC and instruction for the duration. It also services mthi/mtlo writes; mfhi/mflo read Hi/Lo directly.

## Interface
Parameters:
- ITER, 32, number of iterations per operation; fixed at 32 for 32-bit operands.

Ports:
- clock  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  begin operation; accepted only in IDLE.
- Md_op  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- Read_data_1  in  32  rs: multiplicand or dividend.
- Read_data_2  in  32  rt: multiplier or divisor.
- Hi_we  in  1  mthi write strobe.
- Lo_we  in  1  mtlo write strobe.
- Wdata  in  32  mthi/mtlo data (rs).
- Stall  out  1  combinational: busy | (start & IDLE); holds PC and instruction.
- busy  out  1  registered; high while an operation is in flight.
- done  out  1  registered one-cycle pulse; Hi/Lo are valid in this cycle.
- Div_zero  out  1  registered sticky flag; set by a divide with rt==0, cleared at the next accepted start.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - Latch operands and op.
  - Convert to magnitudes when op is signed (01, 11); record the result sign and the dividend sign.
  - count=0, go to CALC.
- CALC, multiply: each cycle, if the multiplier LSB is set, add the multiplicand to the upper 33 bits of the 64-bit accumulator, then shift right 1.
- CALC, divide: each cycle, shift {rem,quot} left 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quot LSB.
- CALC exit: count increments each cycle; after iteration 32 (count==31), go to FIX.
- FIX: apply sign correction, write Hi/Lo, pulse done, go to IDLE.
  - mult: 64-bit two's-complement negate if the signs differ. Hi = product[63:32], Lo = product[31:0].
  - div: quotient negated if the signs differ; remainder takes the dividend's sign. Lo = quotient, Hi = remainder.
  - Divide by zero (detected at start): iterations still run; FIX forces Lo=32'hFFFFFFFF, Hi=rs as latched (unsigned and signed alike); Div_zero=1.
  - Signed 0x80000000 / 0xFFFFFFFF: wraps; Lo=0x80000000, Hi=0.
- mthi/mtlo:
  - Hi_we/Lo_we are honoured only in IDLE with start=0; Hi/Lo take Wdata at the edge.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - Writes during CALC/FIX are ignored; the CPU is stalled then, so none are legal.
- start in CALC/FIX: ignored; it does not queue.
- Md_op is only sampled at the accepting edge.

## Timing
- Reset values: state=IDLE, count=0, busy=0, done=0, Div_zero=0, Hi=0, Lo=0. Stall follows its equation (0 unless start).
- Reset mid-operation: at the next edge, return to IDLE and clear Hi/Lo to 0; the result is discarded and no done pulse follows.
- Start accepted at edge k:
  - busy rises after edge k.
  - CALC occupies cycles after edges k..k+31; FIX occupies the cycle after edge k+32.
  - At edge k+33, Hi/Lo update, done=1 and busy=0.
  - done is high for exactly the one cycle after edge k+33.
- Stall:
  - High in the accept cycle (combinational) and in every busy cycle: 34 cycles total.
  - Low in the done cycle, so the CPU advances on edge k+34.
  - A mfhi issued in the next instruction sees the new Hi.
- Back-to-back: start may be high in the done cycle (state is IDLE) and is accepted at edge k+34.
- Arithmetic:
  - Multiply accumulator is 65 bits internally (carry bit included).
  - Divide remainder register is 33 bits for the trial subtract.
  - All results are truncated to 32-bit Hi/Lo.

## Test plan
- multu 0xFFFFFFFF×0xFFFFFFFF -> after 34 stall cycles, Hi=0xFFFFFFFE, Lo=0x00000001, done one cycle, busy low.
- mult −3 (0xFFFFFFFD) × 5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. mult 0x80000000×0x80000000 -> Hi=0x40000000, Lo=0.
- div −7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. divu 100/7 -> Lo=14, Hi=2. div 0x80000000/−1 -> Lo=0x80000000, Hi=0.
- divu 0x1234/0 -> Lo=0xFFFFFFFF, Hi=0x1234, Div_zero=1. Next start clears Div_zero at its accepting edge.
- Start pulsed again during CALC, then reset asserted at iteration 10 -> second start ignored. After reset: IDLE, Hi=Lo=0, no done; a fresh multu 3×4 -> Lo=12.
- mthi 0xAAAA5555 in IDLE -> Hi=0xAAAA5555 next cycle.
  - Hi_we together with start -> the write is dropped and the mult result lands.
  - mtlo during busy -> Lo unchanged.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-bit multiply/divide sequencer owning the HI/LO pair.
// mult/multu use shift-add, div/divu use restoring division, one bit per cycle.
module muldiv_seq #(
    parameter int unsigned ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  Md_op,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    input  logic        Hi_we,
    input  logic        Lo_we,
    input  logic [31:0] Wdata,
    output logic        Stall,
    output logic        busy,
    output logic        done,
    output logic        Div_zero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic          done_q;
    logic          div_zero_q;
    logic          dz_pend_q;
    logic          is_div_q;
    logic          neg_res_q;
    logic          neg_rem_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   rs_q;
    // Multiplicand (multiply) or divisor magnitude (divide).
    logic [31:0]   opa_q;
    // Multiply: {carry+upper 32, multiplier/lower product}.
    // Divide:   {33-bit remainder, 32-bit quotient}.
    logic [64:0]   acc_q;

    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [32:0]   mul_sum;
    logic [64:0]   mul_step;
    logic [64:0]   div_shift;
    logic [33:0]   div_diff;
    logic [64:0]   div_step;
    logic [64:0]   acc_d;
    logic [63:0]   prod_fix;
    logic [31:0]   quot_fix;
    logic [31:0]   rem_fix;

    // Operand magnitudes, one iteration step of each engine, and final sign fix-up.
    always_comb begin
        a_neg     = Md_op[0] & Read_data_1[31];
        b_neg     = Md_op[0] & Read_data_2[31];
        a_mag     = a_neg ? (~Read_data_1 + 32'd1) : Read_data_1;
        b_mag     = b_neg ? (~Read_data_2 + 32'd1) : Read_data_2;

        mul_sum   = acc_q[64:32] + {1'b0, opa_q};
        mul_step  = acc_q[0] ? {1'b0, mul_sum, acc_q[31:1]} : {1'b0, acc_q[64:1]};

        // Remainder never exceeds 32 bits between steps, so bit 64 is always zero here.
        div_shift = {acc_q[63:0], 1'b0};
        div_diff  = {1'b0, div_shift[64:32]} - {2'b0, opa_q};
        div_step  = div_diff[33] ? div_shift : {div_diff[32:0], div_shift[31:1], 1'b1};

        acc_d     = is_div_q ? div_step : mul_step;

        prod_fix  = neg_res_q ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];
        quot_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    // Sequencer FSM with registered status outputs and the HI/LO registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            rs_q       <= '0;
            opa_q      <= '0;
            acc_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q   <= Md_op[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        dz_pend_q  <= Md_op[1] & (Read_data_2 == '0);
                        rs_q       <= Read_data_1;
                        opa_q      <= Md_op[1] ? b_mag : a_mag;
                        acc_q      <= {33'b0, (Md_op[1] ? a_mag : b_mag)};
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        state_q    <= S_CALC;
                    end else begin
                        if (Hi_we) hi_q <= Wdata;
                        if (Lo_we) lo_q <= Wdata;
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(ITER - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (is_div_q) begin
                        if (dz_pend_q) begin
                            lo_q       <= '1;
                            hi_q       <= rs_q;
                            div_zero_q <= 1'b1;
                        end else begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Stall    = busy_q | (start & (state_q == S_IDLE));
    assign busy     = busy_q;
    assign done     = done_q;
    assign Div_zero = div_zero_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  Md_op;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic        Hi_we;
    logic        Lo_we;
    logic [31:0] Wdata;
    logic        Stall;
    logic        busy;
    logic        done;
    logic        Div_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_seq #(.ITER(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .Md_op       (Md_op),
        .Read_data_1 (Read_data_1),
        .Read_data_2 (Read_data_2),
        .Hi_we       (Hi_we),
        .Lo_we       (Lo_we),
        .Wdata       (Wdata),
        .Stall       (Stall),
        .busy        (busy),
        .done        (done),
        .Div_zero    (Div_zero),
        .Hi          (Hi),
        .Lo          (Lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: MIPS mult/multu/div/divu semantics computed with wide arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] up;
        longint      sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Issue one operation from an IDLE cycle (called #1 after a rising edge) and return in the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic hwe,
                          output int stalls, output int lat, output logic [31:0] hi_acc,
                          output logic dz_acc, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output logic stall_d, output logic busy_d);
        start = 1'b1; Md_op = op; Read_data_1 = a; Read_data_2 = b;
        Hi_we = hwe; Wdata = 32'hDEAD_BEEF;
        #1;
        stalls = Stall ? 1 : 0;
        @(posedge clock); #1;
        start = 1'b0; Hi_we = 1'b0;
        Md_op = 2'($urandom()); Read_data_1 = $urandom(); Read_data_2 = $urandom();
        hi_acc = Hi;
        dz_acc = Div_zero;
        lat = 0;
        while (!done && lat < 100) begin
            if (Stall) stalls++;
            @(posedge clock); #1;
            lat++;
        end
        hi = Hi; lo = Lo; dz = Div_zero; stall_d = Stall; busy_d = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; Hi_we = 1'b0; Lo_we = 1'b0;
        Md_op = '0; Read_data_1 = '0; Read_data_2 = '0; Wdata = '0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_chk++; if (Div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b exp 0", Div_zero); end
        n_chk++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", Hi); end
        n_chk++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", Lo); end
        n_chk++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", Stall); end
        start = 1'b1; #1;
        n_chk++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_start got %b exp 1", Stall); end
        start = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [9]  = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11};
        logic [31:0] as  [9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100,
                                  32'h8000_0000, 32'h1234, 32'd6, 32'hFFFF_FFF0};
        logic [31:0] bs  [9]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2, 32'd7,
                                  32'hFFFF_FFFF, 32'd0, 32'd7, 32'd0};
        logic [31:0] ehs [9]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2,
                                  32'd0, 32'h1234, 32'd0, 32'hFFFF_FFF0};
        logic [31:0] els [9]  = '{32'h0000_0001, 32'hFFFF_FFF1, 32'h0, 32'hFFFF_FFFD, 32'd14,
                                  32'h8000_0000, 32'hFFFF_FFFF, 32'd42, 32'hFFFF_FFFF};
        int stalls, lat; logic [31:0] hi_acc, hi, lo; logic dz_acc, dz, st_d, bz_d;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, stalls, lat, hi_acc, dz_acc, hi, lo, dz, st_d, bz_d);
            n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d exp 33", i, lat); end
            n_chk++; if (stalls !== 34) begin n_fail++; $display("FAIL dir_stalls[%0d] got %0d exp 34", i, stalls); end
            n_chk++; if (hi !== ehs[i]) begin n_fail++; $display("FAIL dir_hi[%0d] got %h exp %h", i, hi, ehs[i]); end
            n_chk++; if (lo !== els[i]) begin n_fail++; $display("FAIL dir_lo[%0d] got %h exp %h", i, lo, els[i]); end
            n_chk++; if (dz !== (ops[i][1] && bs[i] == 0)) begin n_fail++; $display("FAIL dir_dz[%0d] got %b", i, dz); end
            n_chk++; if (dz_acc !== 1'b0) begin n_fail++; $display("FAIL dir_dz_clear[%0d] got %b exp 0", i, dz_acc); end
            n_chk++; if (st_d !== 1'b0 || bz_d !== 1'b0) begin n_fail++; $display("FAIL dir_done_cycle[%0d] stall %b busy %b exp 0 0", i, st_d, bz_d); end
            @(posedge clock); #1;
            n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_width[%0d] got %b exp 0", i, done); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int stalls, lat; logic [31:0] hi_acc, hi, lo; logic dz_acc, dz, st_d, bz_d;
        Hi_we = 1'b1; Wdata = 32'hAAAA_5555;
        @(posedge clock); #1; Hi_we = 1'b0;
        n_chk++; if (Hi !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mthi got %h exp aaaa5555", Hi); end
        Lo_we = 1'b1; Wdata = 32'h1357_9BDF;
        @(posedge clock); #1; Lo_we = 1'b0;
        n_chk++; if (Lo !== 32'h1357_9BDF) begin n_fail++; $display("FAIL mtlo got %h exp 13579bdf", Lo); end
        n_chk++; if (Hi !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mtlo_hi_kept got %h exp aaaa5555", Hi); end
        // Hi_we together with start: start wins.
        run_op(2'b01, 32'd3, 32'd5, 1'b1, stalls, lat, hi_acc, dz_acc, hi, lo, dz, st_d, bz_d);
        n_chk++; if (hi_acc !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mthi_start_dropped got %h exp aaaa5555", hi_acc); end
        n_chk++; if (hi !== 32'h0 || lo !== 32'd15) begin n_fail++; $display("FAIL mthi_start_result got %h_%h exp 0_f", hi, lo); end
        @(posedge clock); #1;
        // mtlo/mthi while busy are ignored.
        start = 1'b1; Md_op = 2'b00; Read_data_1 = 32'd7; Read_data_2 = 32'd9;
        @(posedge clock); #1; start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            Lo_we = 1'b1; Hi_we = 1'b1; Wdata = $urandom();
            @(posedge clock); #1; lat++;
            if (!done) begin
                n_chk++; if (Lo !== 32'd15 || Hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_busy[%0d] got %h_%h exp 0_f", lat, Hi, Lo); end
            end
        end
        Lo_we = 1'b0; Hi_we = 1'b0;
        n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL mtlo_busy_latency got %0d exp 33", lat); end
        n_chk++; if (Lo !== 32'd63 || Hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_busy_result got %h_%h exp 0_3f", Hi, Lo); end
        @(posedge clock); #1;
    endtask

    task automatic test_restart_ignored();
        int lat, extra;
        start = 1'b1; Md_op = 2'b01; Read_data_1 = 32'hFFFF_FFF9; Read_data_2 = 32'd6;
        @(posedge clock); #1; start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            start = (lat == 5);
            Md_op = 2'b10; Read_data_1 = 32'd50; Read_data_2 = 32'd3;
            @(posedge clock); #1; lat++;
        end
        start = 1'b0;
        n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL restart_latency got %0d exp 33", lat); end
        n_chk++; if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFD6) begin n_fail++; $display("FAIL restart_result got %h_%h exp ffffffff_ffffffd6", Hi, Lo); end
        extra = 0;
        repeat (40) begin @(posedge clock); #1; if (done) extra++; end
        n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL restart_no_second_done got %0d exp 0", extra); end
    endtask

    task automatic test_reset_mid();
        int stalls, lat, extra; logic [31:0] hi_acc, hi, lo; logic dz_acc, dz, st_d, bz_d;
        start = 1'b1; Md_op = 2'b00; Read_data_1 = 32'hFFFF_FFFF; Read_data_2 = 32'hFFFF_FFFF;
        @(posedge clock); #1; start = 1'b0;
        repeat (10) @(posedge clock);
        #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL midreset_status busy %b done %b stall %b exp 0 0 0", busy, done, Stall); end
        n_chk++; if (Hi !== 32'h0 || Lo !== 32'h0) begin n_fail++; $display("FAIL midreset_hilo got %h_%h exp 0_0", Hi, Lo); end
        extra = 0;
        repeat (40) begin @(posedge clock); #1; if (done || busy) extra++; end
        n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL midreset_no_done got %0d exp 0", extra); end
        run_op(2'b00, 32'd3, 32'd4, 1'b0, stalls, lat, hi_acc, dz_acc, hi, lo, dz, st_d, bz_d);
        n_chk++; if (lat !== 33 || lo !== 32'd12 || hi !== 32'h0) begin n_fail++; $display("FAIL midreset_fresh got lat %0d %h_%h exp 33 0_c", lat, hi, lo); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int stalls, lat; logic [31:0] hi_acc, hi, lo, eh, el; logic dz_acc, dz, st_d, bz_d;
        logic [1:0] op; logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom()); a = rnd_operand(); b = rnd_operand();
            model(op, a, b, eh, el);
            run_op(op, a, b, 1'b0, stalls, lat, hi_acc, dz_acc, hi, lo, dz, st_d, bz_d);
            n_chk++; if (lat !== 33 || stalls !== 34) begin n_fail++; $display("FAIL b2b_timing[%0d] lat %0d stalls %0d exp 33 34", i, lat, stalls); end
            n_chk++; if (hi !== eh || lo !== el) begin n_fail++; $display("FAIL b2b_result[%0d] op %0d %h,%h got %h_%h exp %h_%h", i, op, a, b, hi, lo, eh, el); end
            n_chk++; if (dz !== (op[1] && b == 0) || dz_acc !== 1'b0) begin n_fail++; $display("FAIL b2b_dz[%0d] got %b/%b", i, dz, dz_acc); end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
                n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_width[%0d] got %b exp 0", i, done); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
